// File: rtl/pipe_skid_register.sv
// One-stage pipeline register with valid/ready on both sides and an internal skid entry.
// InReady depends only on registered state, so upstream sees no combinational ready path.
module pipe_skid_register #(
  parameter int                   DATA_SIZE   = 32,
  parameter logic [DATA_SIZE-1:0] RESET_VALUE = '0
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Flush,
  input  logic [DATA_SIZE-1:0] InData,
  input  logic                 InValid,
  output logic                 InReady,
  output logic [DATA_SIZE-1:0] OutData,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [1:0]           Count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t               state_q;
  logic [DATA_SIZE-1:0] main_q;
  logic [DATA_SIZE-1:0] skid_q;
  logic                 in_ready_q;
  logic                 out_valid_q;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = InValid & in_ready_q;
  assign out_xfer = out_valid_q & OutReady;

  // Reset beats flush, flush beats any handshake; data only loads on a real transfer.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q     <= EMPTY;
      main_q      <= RESET_VALUE;
      skid_q      <= RESET_VALUE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (Flush) begin
      state_q     <= EMPTY;
      main_q      <= RESET_VALUE;
      skid_q      <= RESET_VALUE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          in_ready_q <= 1'b1;
          if (in_xfer) begin
            main_q      <= InData;
            out_valid_q <= 1'b1;
            state_q     <= FULL;
          end
        end
        FULL: begin
          if (out_xfer && in_xfer) begin
            main_q <= InData;
          end else if (out_xfer) begin
            out_valid_q <= 1'b0;
            state_q     <= EMPTY;
          end else if (in_xfer) begin
            skid_q     <= InData;
            in_ready_q <= 1'b0;
            state_q    <= SKID;
          end
        end
        SKID: begin
          if (out_xfer) begin
            main_q     <= skid_q;
            in_ready_q <= 1'b1;
            state_q    <= FULL;
          end
        end
        default: begin
          state_q     <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign InReady  = in_ready_q;
  assign OutData  = main_q;
  assign OutValid = out_valid_q;
  assign Count    = state_q;

endmodule

// File: doc/pipe_skid_register.md
# pipe_skid_register

Parametrised successor to the single enable-gated data register: a one-stage pipeline register with a valid/ready handshake on both sides and an internal skid entry, so upstream ready is fully registered and sustained throughput is one word per cycle with no combinational ready path. It sits between CPU pipeline stages (for example fetch→decode or ALU→writeback). It replaces ad-hoc Enable-based stalling with backpressure and adds a synchronous flush for branch/exception squash.

## Interface
- DATA_SIZE, 32, width of the data path in bits
- RESET_VALUE, 0, value loaded into both data registers on reset and flush
- Clk  input  1  rising-edge clock
- Rst  input  1  synchronous, active-low reset (sampled on posedge Clk; 0 = reset)
- Flush  input  1  synchronous squash of all held words
- InData  input  DATA_SIZE  upstream data
- InValid  input  1  upstream word present
- InReady  output  1  registered; block can accept a word this cycle
- OutData  output  DATA_SIZE  registered downstream data (main entry)
- OutValid  output  1  registered; main entry holds a valid word
- OutReady  input  1  downstream accepts OutData this cycle
- Count  output  2  registered occupancy: 0, 1 or 2

## Operation
- Storage: main entry (drives OutData/OutValid) and skid entry (internal). No combinational input-to-output path.
- Transfer rules: input transfer = InValid & InReady at posedge; output transfer = OutValid & OutReady at posedge.
- States (Count):
  - EMPTY (0): InValid → main ← InData, go to FULL; else stay.
  - FULL (1):
    - OutReady & InValid → main ← InData, stay FULL.
    - OutReady & !InValid → EMPTY.
    - !OutReady & InValid → skid ← InData, go to SKID.
    - neither → hold.
  - SKID (2): InReady = 0. OutReady → main ← skid, go to FULL; else hold.
- InReady = 1 in EMPTY and FULL, 0 in SKID (a function of registered state only).
- Data order is strictly FIFO; no word is dropped or duplicated.
- Flush (Rst high): both entries invalidated, both data registers ← RESET_VALUE, go to EMPTY. The input word offered in that cycle is discarded even if InReady = 1. Flush overrides every handshake in its cycle.
- Rst = 0: same as flush, except InReady ← 0. Priority: Rst > Flush > handshake.
- OutData holds its value while OutValid = 1 and OutReady = 0; downstream may rely on this stability.
- Unknown-free: data registers are never loaded from InData unless an input transfer occurs.

## Timing
- Reset values: OutValid = 0, OutData = RESET_VALUE, Count = 0, InReady = 0.
- InReady rises on the first posedge with Rst = 1 and is visible in the following cycle. Upstream must not count transfers while InReady = 0.
- Latency: an input transfer at edge N in EMPTY gives OutValid = 1 with that data after edge N.
- Throughput: 1 word/cycle sustained when OutReady = 1 continuously.
- Backpressure: after OutReady drops, at most one further word is accepted (into skid). InReady falls after that edge.
- Recovery: in SKID, first edge with OutReady = 1 → FULL and InReady = 1 for the next cycle.
- Flush or reset mid-SKID: both words lost. Count = 0 and OutValid = 0 after the edge.

## Test plan
- Reset: hold Rst = 0 for 3 cycles with InValid = 1, InData = 0xDEADBEEF → OutValid = 0, OutData = 0, Count = 0, InReady = 0. InReady = 1 one cycle after Rst = 1.
- Streaming: OutReady = 1, InValid = 1, InData = 1,2,3…16 on consecutive cycles → OutData = 1…16 on consecutive cycles, first one cycle after input, no gaps, Count stays 1.
- Backpressure: stream 0xA, 0xB, 0xC with OutReady = 0 from the cycle 0xA appears. Result: 0xA in main, 0xB in skid, InReady = 0, Count = 2, 0xC held upstream. Release OutReady → outputs 0xA, 0xB, 0xC in order, none lost.
- Stall hold: FULL with 0x55, OutReady = 0 and InValid = 0 for 10 cycles → OutData stays 0x55, OutValid stays 1.
- Flush in SKID with InValid = 1 and InData = 0x77 → after the edge OutValid = 0, Count = 0, InReady = 1, and 0x77 never appears on OutData.
- Rst wins over Flush: Rst = 0 and Flush = 1 together in the FULL state → reset values, including InReady = 0.
